// File: rtl/chirp_pkg.sv
// ============================================================================
// Module      : chirp_pkg
// Description : Shared constants and state encodings for the chirp TX/RX pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chirp_pkg;

    localparam logic [31:0] PHASE_INC_MAX_BW0 = 32'h0333_3333;
    localparam logic [31:0] PHASE_INC_MAX_BW1 = 32'h0666_6666;
    localparam logic [31:0] PHASE_INC_MAX_BW2 = 32'h0CCC_CCCC;
    localparam logic [31:0] PHASE_INC_MAX_BW3 = 32'h0333_3333;

    localparam int SF_MIN       = 1;
    localparam int SF_MAX       = 12;
    localparam int SF_REG_WIDTH = 4;
    localparam int CNT_WIDTH    = SF_MAX + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] phase_inc_max(input logic [1:0] bw);
        logic [31:0] m;
        case (bw)
            2'd0:    m = PHASE_INC_MAX_BW0;
            2'd1:    m = PHASE_INC_MAX_BW1;
            2'd2:    m = PHASE_INC_MAX_BW2;
            default: m = PHASE_INC_MAX_BW3;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chirp_ref_gen.sv
// ============================================================================
// Module      : chirp_ref_gen
// Description : Reference chirp increment: clear, step by slope, wrap at max.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chirp_ref_gen #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   step,
    input  logic [PHASE_WIDTH-1:0] slope,
    input  logic [PHASE_WIDTH-1:0] max_inc,
    output logic [PHASE_WIDTH-1:0] ref_inc
);

    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH-1:0] ref_next;

    // Sum is one bit wider so a slope near 2^PHASE_WIDTH cannot alias below max.
    assign sum = {1'b0, ref_inc} + {1'b0, slope};

    always_comb begin
        if (sum >= {1'b0, max_inc}) begin
            ref_next = PHASE_WIDTH'(sum - {1'b0, max_inc});
        end else begin
            ref_next = PHASE_WIDTH'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_inc <= '0;
        end else if (clear) begin
            ref_inc <= '0;
        end else if (step) begin
            ref_inc <= ref_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/chirp_demod.sv
// ============================================================================
// Module      : chirp_demod
// Description : Dechirps one symbol of phase samples and estimates its
//               initial per-sample phase increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chirp_demod
    import chirp_pkg::*;
#(
    parameter int PHASE_WIDTH  = 32,
    parameter int MAX_SF_WIDTH = 8,
    parameter int ACC_WIDTH    = 44
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start_n,
    input  logic [MAX_SF_WIDTH-1:0] i_SF,
    input  logic [1:0]              i_bw_config,
    input  logic [PHASE_WIDTH-1:0]  i_slope,
    input  logic [PHASE_WIDTH-1:0]  i_phase,
    input  logic                    i_sample_tick_n,
    output logic [PHASE_WIDTH-1:0]  o_inc_est,
    output logic                    o_busy,
    output logic                    o_done_n
);

    localparam int TW = PHASE_WIDTH + 1;

    state_t state, state_next;

    logic                    tick_d;
    logic                    tick;
    logic [SF_REG_WIDTH-1:0] sf_clamped;
    logic [SF_REG_WIDTH-1:0] sf;
    logic [PHASE_WIDTH-1:0]  max_inc;
    logic [PHASE_WIDTH-1:0]  slope;
    logic [PHASE_WIDTH-1:0]  prev;
    logic [PHASE_WIDTH-1:0]  ref_inc;
    logic [ACC_WIDTH-1:0]    acc;
    logic [CNT_WIDTH-1:0]    count;
    logic [CNT_WIDTH-1:0]    count_inc;
    logic [CNT_WIDTH-1:0]    n_samples;

    logic [PHASE_WIDTH-1:0]  diff;
    logic signed [TW-1:0]    t;
    logic signed [TW-1:0]    fold;
    logic signed [TW-1:0]    max_s;
    logic [PHASE_WIDTH-1:0]  err;

    logic load;
    logic prime_load;
    logic accum_en;
    logic finish;

    assign tick      = tick_d & ~i_sample_tick_n;
    assign count_inc = count + CNT_WIDTH'(1);
    assign n_samples = CNT_WIDTH'(1) << sf;
    assign o_busy    = (state == ST_PRIME) || (state == ST_ACCUM);

    always_comb begin
        if (i_SF == '0) begin
            sf_clamped = SF_REG_WIDTH'(SF_MIN);
        end else if (i_SF > MAX_SF_WIDTH'(SF_MAX)) begin
            sf_clamped = SF_REG_WIDTH'(SF_MAX);
        end else begin
            sf_clamped = SF_REG_WIDTH'(i_SF);
        end
    end

    // Dechirp: remove the reference increment, then fold back into [0, max).
    assign diff  = i_phase - prev;
    assign max_s = $signed({1'b0, max_inc});
    assign t     = $signed({1'b0, diff}) - $signed({1'b0, ref_inc});

    always_comb begin
        if (t[TW-1]) begin
            fold = t + max_s;
        end else if (t >= max_s) begin
            fold = t - max_s;
        end else begin
            fold = t;
        end
        if (fold[TW-1]) begin
            err = '0;
        end else if (fold >= max_s) begin
            err = max_inc - PHASE_WIDTH'(1);
        end else begin
            err = fold[PHASE_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        prime_load = 1'b0;
        accum_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!i_start_n) begin
                    load       = 1'b1;
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (tick) begin
                    prime_load = 1'b1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (tick) begin
                    accum_en = 1'b1;
                    if (count_inc == n_samples) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                finish     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_d    <= 1'b1;
            sf        <= SF_REG_WIDTH'(SF_MIN);
            max_inc   <= '0;
            slope     <= '0;
            prev      <= '0;
            acc       <= '0;
            count     <= '0;
            o_inc_est <= '0;
            o_done_n  <= 1'b1;
        end else begin
            tick_d   <= i_sample_tick_n;
            o_done_n <= ~finish;
            if (load) begin
                sf      <= sf_clamped;
                max_inc <= PHASE_WIDTH'(phase_inc_max(i_bw_config));
                slope   <= i_slope;
                acc     <= '0;
                count   <= '0;
            end
            if (prime_load) begin
                prev <= i_phase;
            end
            if (accum_en) begin
                acc   <= acc + ACC_WIDTH'(err);
                prev  <= i_phase;
                count <= count_inc;
            end
            if (finish) begin
                o_inc_est <= PHASE_WIDTH'(acc >> sf);
            end
        end
    end

    chirp_ref_gen #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_ref_gen (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (load),
        .step    (accum_en),
        .slope   (slope),
        .max_inc (max_inc),
        .ref_inc (ref_inc)
    );

endmodule

`default_nettype wire

// File: tb/tb_chirp_demod.sv
// ============================================================================
// Module      : tb_chirp_demod
// Description : Scoreboard bench for chirp_demod symbol estimation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chirp_demod;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_n;
    logic [7:0]  sf;
    logic [1:0]  bw;
    logic [31:0] slope;
    logic [31:0] phase;
    logic        tick_n;
    wire  [31:0] inc_est;
    wire         busy;
    wire         done_n;

    int checks      = 0;
    int errors      = 0;
    int done_pulses = 0;
    logic [31:0] exp_q[$];

    chirp_demod #(
        .PHASE_WIDTH  (32),
        .MAX_SF_WIDTH (8),
        .ACC_WIDTH    (44)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start_n       (start_n),
        .i_SF            (sf),
        .i_bw_config     (bw),
        .i_slope         (slope),
        .i_phase         (phase),
        .i_sample_tick_n (tick_n),
        .o_inc_est       (inc_est),
        .o_busy          (busy),
        .o_done_n        (done_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_n === 1'b0) done_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    function automatic longint bw_max(input logic [1:0] b);
        case (b)
            2'd1:    return 64'h0666_6666;
            2'd2:    return 64'h0CCC_CCCC;
            default: return 64'h0333_3333;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [31:0] ph);
        phase  = ph;
        tick_n = 1'b0;
        step();
        tick_n = 1'b1;
        step();
    endtask

    task automatic start_sym(input logic [7:0] s, input logic [1:0] b, input logic [31:0] sl);
        sf      = s;
        bw      = b;
        slope   = sl;
        start_n = 1'b0;
        step();
        start_n = 1'b1;
    endtask

    task automatic wait_done(output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_n === 1'b0) begin
                seen = 1'b1;
                break;
            end
            waited++;
        end
    endtask

    // Prime tick, then n accumulate ticks of a transmitted chirp whose
    // increment starts at inc0 and grows by sl each sample, wrapping at mx.
    task automatic send_chirp(input logic [31:0] phase0, input logic [31:0] inc0,
                              input logic [31:0] sl, input longint mx, input int n,
                              output int early);
        logic [31:0] ph;
        longint      inc;
        int          base;
        base  = done_pulses;
        early = 0;
        ph    = phase0;
        tick(ph);
        for (int k = 0; k < n; k++) begin
            inc = (longint'(inc0) + longint'(k) * longint'(sl)) % mx;
            ph  = ph + inc[31:0];
            if (k == n - 1) early = done_pulses - base;
            tick(ph);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_n = 1'b1; sf = '0; bw = '0; slope = '0; phase = '0; tick_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++; if (inc_est !== 32'h0) begin errors++; $display("FAIL reset_inc_est: got %h expected 00000000", inc_est); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done_n !== 1'b1) begin errors++; $display("FAIL reset_done_n: got %b expected 1", done_n); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean();
        bit seen; int waited, early, base; logic [31:0] exp;
        base = done_pulses;
        exp_q.push_back(32'h0080_0000);
        start_sym(8'd4, 2'd0, 32'h0010_0000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_prime: got %b expected 1", busy); end
        send_chirp(32'h1000_0000, 32'h0080_0000, 32'h0010_0000, 64'h0333_3333, 16, early);
        checks++; if (early != 0) begin errors++; $display("FAIL clean_early_done: got %0d pulses expected 0", early); end
        wait_done(seen, waited);
        checks++; if (!seen || waited != 0) begin errors++; $display("FAIL clean_latency: got seen=%0d waited=%0d expected seen=1 waited=0", seen, waited); end
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL clean_est: got %h expected %h", inc_est, exp); end
        end else exp_q.delete();
        @(negedge clk);
        checks++; if (done_n !== 1'b1) begin errors++; $display("FAIL clean_pulse_width: got done_n=%b expected 1", done_n); end
        checks++; if (done_pulses - base != 1) begin errors++; $display("FAIL clean_pulse_count: got %0d expected 1", done_pulses - base); end
        step();
    endtask

    task automatic test_wrap();
        bit seen; int waited, early; logic [31:0] exp;
        exp_q.push_back(32'h0300_0000);
        start_sym(8'd5, 2'd0, 32'h0040_0000);
        send_chirp(32'h0000_0000, 32'h0300_0000, 32'h0040_0000, 64'h0333_3333, 32, early);
        checks++; if (early != 0) begin errors++; $display("FAIL wrap_early_done: got %0d expected 0", early); end
        wait_done(seen, waited);
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL wrap_est: got %h expected %h", inc_est, exp); end
        end else begin
            exp_q.delete();
            checks++; errors++; $display("FAIL wrap_done: got no pulse expected one");
        end
        step();
    endtask

    task automatic test_start_held();
        bit seen; int waited, base, busy_bad; logic [31:0] ph, exp; longint inc;
        base = done_pulses; busy_bad = 0;
        exp_q.push_back(32'h0080_0000);
        sf = 8'd4; bw = 2'd0; slope = 32'h0010_0000; start_n = 1'b0;
        step();
        ph = 32'h2222_0000;
        tick(ph);
        for (int k = 0; k < 16; k++) begin
            if (k == 8) start_n = 1'b1;
            if (k == 11) begin start_n = 1'b0; step(); start_n = 1'b1; end
            if (k == 15) start_n = 1'b1;
            if (busy !== 1'b1) busy_bad++;
            inc = longint'(32'h0080_0000) + longint'(k) * longint'(32'h0010_0000);
            ph  = ph + inc[31:0];
            tick(ph);
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL held_busy: got %0d low samples expected 0", busy_bad); end
        wait_done(seen, waited);
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL held_est: got %h expected %h", inc_est, exp); end
        end else exp_q.delete();
        repeat (6) step();
        checks++; if (done_pulses - base != 1) begin errors++; $display("FAIL held_pulse_count: got %0d expected 1", done_pulses - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_same_cycle();
        bit seen; int waited, early; logic [31:0] exp;
        exp_q.push_back(32'h0080_0000);
        sf = 8'd4; bw = 2'd0; slope = 32'h0010_0000;
        phase = 32'hDEAD_BEEF; start_n = 1'b0; tick_n = 1'b0;
        step();
        start_n = 1'b1; tick_n = 1'b1;
        step();
        send_chirp(32'h0555_0000, 32'h0080_0000, 32'h0010_0000, 64'h0333_3333, 16, early);
        checks++; if (early != 0) begin errors++; $display("FAIL same_early_done: got %0d expected 0", early); end
        wait_done(seen, waited);
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL same_est: got %h expected %h", inc_est, exp); end
        end else begin
            exp_q.delete();
            checks++; errors++; $display("FAIL same_done: got no pulse expected one");
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit seen; int waited, early, base; logic [31:0] ph, exp;
        exp_q.push_back(32'h0080_0000);
        start_sym(8'd4, 2'd0, 32'h0010_0000);
        ph = 32'h0;
        for (int k = 0; k < 7; k++) begin
            tick(ph);
            ph = ph + 32'h0080_0000 + 32'(k) * 32'h0010_0000;
        end
        base  = done_pulses;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        repeat (8) step();
        checks++; if (done_pulses != base) begin errors++; $display("FAIL rstmid_done: got %0d pulses expected 0", done_pulses - base); end
        checks++; if (inc_est !== 32'h0) begin errors++; $display("FAIL rstmid_est: got %h expected 00000000", inc_est); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        exp_q.push_back(32'h0080_0000);
        start_sym(8'd4, 2'd0, 32'h0010_0000);
        send_chirp(32'h7000_0000, 32'h0080_0000, 32'h0010_0000, 64'h0333_3333, 16, early);
        wait_done(seen, waited);
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL rstmid_restart_est: got %h expected %h", inc_est, exp); end
        end else begin
            exp_q.delete();
            checks++; errors++; $display("FAIL rstmid_restart_done: got no pulse expected one");
        end
        step();
    endtask

    task automatic test_sf0_sat();
        bit seen; int waited; logic [31:0] exp;
        exp_q.push_back(32'h0333_3332);
        start_sym(8'd0, 2'd0, 32'h0);
        tick(32'h0000_0010);
        tick(32'h0000_000F);
        tick(32'h0000_000E);
        wait_done(seen, waited);
        checks++; if (!seen || waited != 0) begin errors++; $display("FAIL sf0_latency: got seen=%0d waited=%0d expected seen=1 waited=0", seen, waited); end
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL sf0_sat_est: got %h expected %h", inc_est, exp); end
        end else exp_q.delete();
        step();
    endtask

    // Random phases with an independent spec model, for each wider bandwidth.
    task automatic test_random();
        bit seen; int waited; logic [31:0] exp, sl; logic [31:0] ph[9];
        longint mx, prevm, refm, acc, d, t;
        for (int b = 1; b < 4; b++) begin
            mx = bw_max(2'(b));
            sl = 32'($urandom % 32'(mx));
            for (int i = 0; i < 9; i++) ph[i] = $urandom;
            prevm = longint'(ph[0]); refm = 0; acc = 0;
            for (int i = 1; i < 9; i++) begin
                d = (longint'(ph[i]) - prevm) & 64'hFFFF_FFFF;
                t = d - refm;
                if (t < 0) t = t + mx;
                else if (t >= mx) t = t - mx;
                if (t >= mx) t = mx - 1;
                else if (t < 0) t = 0;
                acc   = acc + t;
                prevm = longint'(ph[i]);
                refm  = refm + longint'(sl);
                if (refm >= mx) refm = refm - mx;
            end
            exp_q.push_back(32'((acc >> 3) & 64'hFFFF_FFFF));
            start_sym(8'd3, 2'(b), sl);
            for (int i = 0; i < 9; i++) tick(ph[i]);
            wait_done(seen, waited);
            if (seen) begin
                exp = exp_q.pop_front();
                checks++; if (inc_est !== exp) begin errors++; $display("FAIL random_bw%0d_est: got %h expected %h", b, inc_est, exp); end
            end else begin
                exp_q.delete();
                checks++; errors++; $display("FAIL random_bw%0d_done: got no pulse expected one", b);
            end
            step();
        end
    endtask

    task automatic test_sf_clamp_high();
        bit seen; int waited, early; logic [31:0] exp;
        exp_q.push_back(32'h0123_4567);
        start_sym(8'd200, 2'd2, 32'h0001_0000);
        send_chirp(32'h0ABC_0000, 32'h0123_4567, 32'h0001_0000, 64'h0CCC_CCCC, 4096, early);
        checks++; if (early != 0) begin errors++; $display("FAIL sfhigh_early_done: got %0d expected 0", early); end
        wait_done(seen, waited);
        if (seen) begin
            exp = exp_q.pop_front();
            checks++; if (inc_est !== exp) begin errors++; $display("FAIL sfhigh_est: got %h expected %h", inc_est, exp); end
        end else begin
            exp_q.delete();
            checks++; errors++; $display("FAIL sfhigh_done: got no pulse expected one");
        end
        step();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_wrap();
        test_start_held();
        test_same_cycle();
        test_reset_mid();
        test_sf0_sat();
        test_random();
        test_sf_clamp_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
